// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO management master: serialises one 64-bit read/write frame per command.
// Optional build macro ETH_MDIO_TA_CHECK_EN adds the bit-47 turnaround check driving rsp_err.
module eth_mdio_ctrl #(
    parameter int CLK_DIV = 20
) (
    input  logic        msoc_clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        mdc_q, mdc_d;
    logic        wr_q, wr_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [15:0] rdata_q, rdata_d;
    logic [63:0] frame_q, frame_d;
    logic [15:0] rx_q, rx_d;
    logic        sync1_q, sync2_q;
    logic [5:0]  bit_nx;
    logic        wrap;
`ifdef ETH_MDIO_TA_CHECK_EN
    logic        ta_q, ta_d;
`endif

    assign bit_nx = bit_q + 6'd1;
    assign wrap   = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        mdc_d     = mdc_q;
        wr_d      = wr_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        rdata_d   = rdata_q;
        frame_d   = frame_q;
        rx_d      = rx_q;
`ifdef ETH_MDIO_TA_CHECK_EN
        ta_d      = ta_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d   = S_PRE;
                    div_d     = '0;
                    bit_d     = '0;
                    mdc_d     = 1'b0;
                    wr_d      = cmd_write;
                    frame_d   = {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10),
                                 cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata};
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                div_d = wrap ? 8'd0 : div_q + 8'd1;
                if (wrap) begin
                    mdc_d = ~mdc_q;
                    if (!mdc_q) begin
                        // MDC rising edge: sample the synchronised pad input
                        if (state_q == S_DATA) rx_d = {rx_q[14:0], sync2_q};
`ifdef ETH_MDIO_TA_CHECK_EN
                        if (bit_q == 6'd47) ta_d = sync2_q;
`endif
                    end else if (bit_q == 6'd63) begin
                        state_d   = S_DONE;
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b1;
                        if (!wr_q) rdata_d = rx_q;
                    end else begin
                        bit_d     = bit_nx;
                        frame_d   = {frame_q[62:0], 1'b0};
                        mdio_oe_d = wr_q || (bit_nx < 6'd46);
                        mdio_o_d  = frame_q[62] || !mdio_oe_d;
                        if (bit_nx == 6'd32)      state_d = S_HDR;
                        else if (bit_nx == 6'd46) state_d = S_TA;
                        else if (bit_nx == 6'd48) state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            mdc_q     <= 1'b0;
            wr_q      <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            rdata_q   <= '0;
`ifdef ETH_MDIO_TA_CHECK_EN
            ta_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            mdc_q     <= mdc_d;
            wr_q      <= wr_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            rdata_q   <= rdata_d;
`ifdef ETH_MDIO_TA_CHECK_EN
            ta_q      <= ta_d;
`endif
        end
    end

    // Datapath shifters and pad synchroniser carry no reset; each frame reloads them
    always_ff @(posedge msoc_clk) begin
        frame_q <= frame_d;
        rx_q    <= rx_d;
        sync1_q <= mdio_i;
        sync2_q <= sync1_q;
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_rdata = rdata_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
`ifdef ETH_MDIO_TA_CHECK_EN
    assign rsp_err   = (state_q == S_DONE) && !wr_q && ta_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Bench for eth_mdio_ctrl: directed table, random commands against a frame-level model,
// mid-frame reset, and a CLK_DIV=255 timing instance.
`timescale 1ns/1ps
module tb_eth_mdio_ctrl;
    localparam int CD  = 2;
    localparam int CDB = 255;
`ifdef ETH_MDIO_TA_CHECK_EN
    localparam bit TA_EN = 1'b1;
`else
    localparam bit TA_EN = 1'b0;
`endif

    typedef struct {
        bit        wr;
        bit [4:0]  phy;
        bit [4:0]  rg;
        bit [15:0] wdata;
        bit        phy_en;
        bit [15:0] phy_data;
        bit [15:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rstn, cmd_valid, cmd_write, mdio_i;
    logic [4:0] cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_wdata, rsp_rdata;
    logic cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;

    logic rstn_b, cmd_valid_b, cmd_write_b, mdio_i_b;
    logic [4:0] cmd_phy_addr_b, cmd_reg_addr_b;
    logic [15:0] cmd_wdata_b, rsp_rdata_b;
    logic cmd_ready_b, rsp_valid_b, rsp_err_b, busy_b, mdc_b, mdio_o_b, mdio_oe_b;

    eth_mdio_ctrl #(.CLK_DIV(CD)) dut (
        .msoc_clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    eth_mdio_ctrl #(.CLK_DIV(CDB)) dut_b (
        .msoc_clk(clk), .rstn(rstn_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_write(cmd_write_b), .cmd_phy_addr(cmd_phy_addr_b), .cmd_reg_addr(cmd_reg_addr_b),
        .cmd_wdata(cmd_wdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .busy(busy_b), .mdc(mdc_b), .mdio_o(mdio_o_b), .mdio_oe(mdio_oe_b), .mdio_i(mdio_i_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] last_rdata = 16'h0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as the wire should carry it; released bits read back as 1 (mdio_o idles high)
    function automatic logic [63:0] exp_frame(input vec_t v);
        if (v.wr) return {32'hFFFF_FFFF, 2'b01, 2'b01, v.phy, v.rg, 2'b10, v.wdata};
        return {32'hFFFF_FFFF, 2'b01, 2'b10, v.phy, v.rg, 18'h3FFFF};
    endfunction

    function automatic logic [63:0] exp_oe(input vec_t v);
        return v.wr ? 64'hFFFF_FFFF_FFFF_FFFF : {{46{1'b1}}, 18'h0};
    endfunction

    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        if (!v.wr) last_rdata = v.phy_en ? v.phy_data : 16'hFFFF;
        r.exp_rdata = last_rdata;
        r.exp_err   = !v.wr && !v.phy_en && TA_EN;
        return r;
    endfunction

    // PHY model: value presented for bit b, set after the MDC rise that sampled bit b-1
    task automatic phy_drive(input vec_t v, input int b);
        mdio_i = 1'b1;
        if (v.phy_en && !v.wr) begin
            if (b == 47) mdio_i = 1'b0;
            else if (b >= 48 && b <= 63) mdio_i = v.phy_data[63-b];
        end
    endtask

    task automatic accept_cmd(input vec_t v, output int unsigned t_acc);
        int n = 0;
        cmd_write = v.wr; cmd_phy_addr = v.phy; cmd_reg_addr = v.rg; cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        mdio_i = 1'b1;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        t_acc = cyc;
        chk("accept_ready", cmd_ready, 1'b1);
        chk("idle_pins", {rsp_valid, busy, mdc, mdio_oe, mdio_o}, 5'b00001);
    endtask

    task automatic run_cmd(input vec_t v, input bit hold, input bit b2b, input int unsigned prev_rsp,
                           output int unsigned t_rsp, output logic [63:0] cap_o);
        int unsigned t_acc;
        logic [63:0] cap_oe;
        int nrise;
        bit seen, prev_mdc, bad_stable, bad_busy, bad_rel;
        logic prev_o, prev_oe;
        accept_cmd(v, t_acc);
        if (b2b) chk("b2b_accept_cycle", t_acc, prev_rsp + 1);
        @(negedge clk);
        if (hold) begin
            cmd_write = ~v.wr; cmd_phy_addr = ~v.phy; cmd_reg_addr = ~v.rg; cmd_wdata = ~v.wdata;
        end else cmd_valid = 1'b0;
        chk("first_bit_pins", {mdc, mdio_oe, mdio_o}, 3'b011);
        nrise = 0; seen = 0; prev_mdc = 1'b0; bad_stable = 0; bad_busy = 0; bad_rel = 0;
        prev_o = mdio_o; prev_oe = mdio_oe; cap_o = '0; cap_oe = '0; t_rsp = cyc;
        for (int k = 1; k <= 128*CD + 20; k++) begin
            if (rsp_valid) begin
                seen = 1; t_rsp = cyc;
                break;
            end
            if (!busy || cmd_ready) bad_busy = 1;
            if (!mdio_oe && !mdio_o) bad_rel = 1;
            if ((mdio_o !== prev_o || mdio_oe !== prev_oe) && !(prev_mdc && !mdc)) bad_stable = 1;
            if (mdc && !prev_mdc) begin
                if (nrise < 64) begin
                    cap_o[63-nrise]  = mdio_o;
                    cap_oe[63-nrise] = mdio_oe;
                end
                phy_drive(v, nrise + 1);
                nrise++;
            end
            prev_mdc = mdc; prev_o = mdio_o; prev_oe = mdio_oe;
            @(negedge clk);
        end
        chk("rsp_seen", seen, 1'b1);
        chk("latency", t_rsp - t_acc, 128*CD + 1);
        chk("mdc_rises", nrise, 64);
        chk("frame_bits", cap_o, exp_frame(v));
        chk("oe_bits", cap_oe, exp_oe(v));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("done_pins", {mdc, mdio_oe, mdio_o, cmd_ready}, 4'b0010);
        chk("busy_during_frame", bad_busy, 1'b0);
        chk("released_high", bad_rel, 1'b0);
        chk("pins_move_on_mdc_fall", bad_stable, 1'b0);
        if (hold) cmd_valid = 1'b0;
        mdio_i = 1'b1;
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        int unsigned t_rsp, t_acc, prev;
        logic [63:0] cap;
        int nrise, k, run, nph, badph, gap;
        bit pm, seen;

        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy_addr = '0; cmd_reg_addr = '0;
        cmd_wdata = '0; mdio_i = 1'b1;
        rstn_b = 1'b0; cmd_valid_b = 1'b0; cmd_write_b = 1'b0; cmd_phy_addr_b = '0;
        cmd_reg_addr_b = '0; cmd_wdata_b = '0; mdio_i_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o, rsp_rdata},
            {7'b1000001, 16'h0000});
        rstn = 1'b1; rstn_b = 1'b1;
        @(negedge clk);

        tbl[0] = '{1'b1, 5'h01, 5'h00, 16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0022, 16'h0022, 1'b0};
        tbl[2] = '{1'b0, 5'h05, 5'h03, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, TA_EN};
        tbl[3] = '{1'b1, 5'h1F, 5'h1F, 16'h5A5A, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
        tbl[4] = '{1'b0, 5'h03, 5'h04, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0};
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_cmd(tbl[i], (i == 3), (i > 0), prev, t_rsp, cap);
            if (i == 0) chk("write_frame_literal", cap, 64'hFFFF_FFFF_5082_8000);
            prev = t_rsp;
        end
        last_rdata = 16'hA5C3;

        for (int i = 0; i < 16; i++) begin
            v.wr = 1'($urandom); v.phy = 5'($urandom); v.rg = 5'($urandom);
            v.wdata = 16'($urandom); v.phy_en = ($urandom_range(0, 3) != 0);
            v.phy_data = 16'($urandom);
            v = ref_model(v);
            gap = $urandom_range(0, 2);
            if (gap > 0) repeat (gap) @(negedge clk);
            run_cmd(v, 1'($urandom), (gap == 0), prev, t_rsp, cap);
            prev = t_rsp;
        end

        // Reset during bit 40 of a write
        v = '{1'b1, 5'h02, 5'h11, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b0};
        accept_cmd(v, t_acc);
        @(negedge clk);
        cmd_valid = 1'b0;
        nrise = 0; k = 0; pm = mdc;
        while (nrise < 41 && k < 128*CD) begin
            @(negedge clk);
            k++;
            if (mdc && !pm) nrise++;
            pm = mdc;
        end
        chk("pre_reset_pins", {mdc, mdio_oe}, 2'b11);
        #1 rstn = 1'b0;
        #1 chk("async_reset_pins", {mdc, mdio_oe, mdio_o, cmd_ready, busy, rsp_valid, rsp_rdata},
               {6'b001100, 16'h0000});
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (128*CD + 8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("no_rsp_after_reset", seen, 1'b0);
        last_rdata = 16'h0000;
        v = '{1'b0, 5'h07, 5'h01, 16'h0000, 1'b1, 16'h796D, 16'h0000, 1'b0};
        v = ref_model(v);
        run_cmd(v, 1'b0, 1'b0, 0, t_rsp, cap);

        // CLK_DIV=255 instance: phase lengths and latency
        cmd_write_b = 1'b0; cmd_phy_addr_b = 5'h01; cmd_reg_addr_b = 5'h01; cmd_valid_b = 1'b1;
        chk("big_ready", cmd_ready_b, 1'b1);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        pm = mdc_b; run = 1; nph = 0; badph = 0; seen = 0; t_rsp = cyc;
        for (int j = 0; j < 128*CDB + 20; j++) begin
            @(negedge clk);
            if (mdc_b == pm) run++;
            else begin
                nph++;
                if (run != CDB) badph++;
                run = 1;
                pm = mdc_b;
            end
            if (rsp_valid_b) begin
                seen = 1; t_rsp = cyc;
                break;
            end
        end
        chk("big_rsp_seen", seen, 1'b1);
        chk("big_latency", t_rsp - t_acc, 32641);
        chk("big_phase_count", nph, 128);
        chk("big_bad_phases", badph, 0);
        chk("big_rdata", rsp_rdata_b, 16'hFFFF);
        chk("big_err", rsp_err_b, TA_EN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
